// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer and the PC / ROM / fetch-register datapath.
// The optional step input exists only when SEQ_STEP_EN is defined.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 12
);
    logic              start;
    logic              flag_z;
    logic [3:0]        instr;
    logic [3:0]        oprnd;
    logic [7:0]        P_B;
    logic              ENPC;
    logic              ENF;
    logic              blo;
    logic [ADDR_W-1:0] load;
    logic              exec_en;
    logic              busy;
    logic              halted;
`ifdef SEQ_STEP_EN
    logic              step;

    modport master (
        input  start, flag_z, instr, oprnd, P_B, step,
        output ENPC, ENF, blo, load, exec_en, busy, halted
    );
    modport slave (
        output start, flag_z, instr, oprnd, P_B, step,
        input  ENPC, ENF, blo, load, exec_en, busy, halted
    );
`else
    modport master (
        input  start, flag_z, instr, oprnd, P_B,
        output ENPC, ENF, blo, load, exec_en, busy, halted
    );
    modport slave (
        output start, flag_z, instr, oprnd, P_B,
        input  ENPC, ENF, blo, load, exec_en, busy, halted
    );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/decode/branch controller for the PC + program ROM + fetch register datapath.
// Optional single-step mode is enabled by defining SEQ_STEP_EN (adds bus.step and S_WAIT).
module fetch_sequencer #(
    parameter int         ADDR_W  = 12,
    parameter logic [3:0] OPC_JMP = 4'h8,
    parameter logic [3:0] OPC_JZ  = 4'h9,
    parameter logic [3:0] OPC_HLT = 4'hF
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.master  bus,
    output logic [2:0]         state_o
);

    // start and step are level inputs: a 1 sampled on a rising edge in S_IDLE
    // (start) or S_WAIT (step) is consumed by leaving that state; no acknowledge.
`ifdef SEQ_STEP_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_JUMP   = 3'd3,
        S_SKIP   = 3'd4,
        S_HALT   = 3'd5,
        S_WAIT   = 3'd6
    } state_t;
    localparam state_t S_RESUME = S_WAIT;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_JUMP   = 3'd3,
        S_SKIP   = 3'd4,
        S_HALT   = 3'd5
    } state_t;
    localparam state_t S_RESUME = S_FETCH;
`endif

    state_t state_q, state_d;
    logic   is_ctrl;

    assign is_ctrl = (bus.instr == OPC_JMP) || (bus.instr == OPC_JZ) ||
                     (bus.instr == OPC_HLT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (bus.instr == OPC_HLT)
                    state_d = S_HALT;
                else if ((bus.instr == OPC_JMP) || ((bus.instr == OPC_JZ) && bus.flag_z))
                    state_d = S_JUMP;
                else if (bus.instr == OPC_JZ)
                    state_d = S_SKIP;
                else
                    state_d = S_RESUME;
            end
            S_JUMP:   state_d = S_RESUME;
            S_SKIP:   state_d = S_RESUME;
            S_HALT:   state_d = S_HALT;
`ifdef SEQ_STEP_EN
            S_WAIT:   if (bus.step) state_d = S_FETCH;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Outputs decode the registered state only, so an asserted reset clears
    // them in the same cycle. In S_JUMP the PC points at the target low byte.
    assign bus.ENF     = (state_q == S_FETCH);
    assign bus.ENPC    = (state_q == S_FETCH) || (state_q == S_SKIP);
    assign bus.blo     = (state_q == S_JUMP);
    assign bus.load    = (state_q == S_JUMP) ? ADDR_W'({bus.oprnd, bus.P_B}) : '0;
    assign bus.exec_en = (state_q == S_DECODE) && !is_ctrl;
    assign bus.busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.halted  = (state_q == S_HALT);
    assign state_o     = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural PC/ROM/fetch-register datapath, directed
// programs, and a scoreboard of expected fetch/exec/jump/skip/halt events.
module tb_fetch_sequencer;

    localparam int W = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] state_o;

    logic [7:0]  rom [0:4095];
    logic [11:0] pc;
    logic [11:0] pc_init = 12'h000;
    logic [7:0]  fr;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    fetch_sequencer_if #(.ADDR_W(12)) bus ();

    fetch_sequencer dut (
        .clk     (clk),
        .reset   (rst_n),
        .bus     (bus.master),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    // Datapath model: PC with increment / parallel load, fetch register, ROM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= pc_init;
            fr <= 8'h00;
        end else begin
            if (bus.blo)       pc <= bus.load;
            else if (bus.ENPC) pc <= pc + 12'd1;
            if (bus.ENF)       fr <= bus.P_B;
        end
    end

    assign bus.P_B   = rom[pc];
    assign bus.instr = fr[7:4];
    assign bus.oprnd = fr[3:0];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic sb_event(input string name, input logic [W-1:0] got);
        logic [W-1:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got unexpected event %0h expected none", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", name, got, exp);
            end
        end
    endtask

    // Monitor: event codes {kind, 12-bit data}
    //   1: exec {instr,oprnd}   2: jump load   3: skip at pc   4: halt at pc   5: fetch at pc
    initial begin : monitor
        logic halted_prev;
        halted_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("enpc_blo_exclusive", {31'd0, bus.ENPC & bus.blo}, 32'd0);
                chk("outputs_known",
                    {31'd0, $isunknown({bus.ENPC, bus.ENF, bus.blo, bus.load,
                                        bus.exec_en, bus.busy, bus.halted})}, 32'd0);
                if (bus.ENF)              sb_event("fetch", {4'h5, pc});
                if (bus.exec_en)          sb_event("exec", {4'h1, 4'h0, bus.instr, bus.oprnd});
                if (bus.blo)              sb_event("jump", {4'h2, bus.load});
                if (bus.ENPC && !bus.ENF) sb_event("skip", {4'h3, pc});
                if (bus.halted && !halted_prev) sb_event("halt", {4'h4, pc});
                halted_prev = bus.halted;
            end else begin
                halted_prev = 1'b0;
            end
        end
    end

    task automatic do_reset(input logic [11:0] pc0);
        pc_init   = pc0;
        bus.start = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        exp_q.delete();
        #12;
        chk("reset_outputs", {25'd0, bus.ENPC, bus.ENF, bus.blo, bus.exec_en,
                              bus.busy, bus.halted, |bus.load}, 32'd0);
        chk("reset_state", {29'd0, state_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_run(input bit hold);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic wait_halt(output int n);
        n = 0;
        while (!bus.halted && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.halted) chk("halt_timeout", 32'd0, 32'd1);
    endtask

    task automatic end_test(input string name);
        repeat (3) @(negedge clk);
        #1;
        chk(name, exp_q.size(), 32'd0);
        bus.start = 1'b0;
    endtask

    initial begin : stimulus
        int n;
        bus.start  = 1'b0;
        bus.flag_z = 1'b0;
`ifdef SEQ_STEP_EN
        bus.step   = 1'b1;
`endif

        // Reset while in S_JUMP clears blo/load/busy immediately.
        do_reset(12'h000);
        rom[0] = 8'h84; rom[1] = 8'h10;
        exp_q.push_back(16'h5000);
        exp_q.push_back(16'h2410);
        start_run(1'b0);
        n = 0;
        while (!bus.blo && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reach_jump", {31'd0, bus.blo}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midjump_reset_blo", {31'd0, bus.blo}, 32'd0);
        chk("midjump_reset_load", {20'd0, bus.load}, 32'd0);
        chk("midjump_reset_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_state", {29'd0, state_o}, 32'd0);
        chk("post_reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("t1_queue_empty", exp_q.size(), 32'd0);

        // Two plain opcodes then halt.
        do_reset(12'h000);
        rom[0] = 8'h13; rom[1] = 8'h25; rom[2] = 8'hF0;
        exp_q.push_back(16'h5000); exp_q.push_back(16'h1013);
        exp_q.push_back(16'h5001); exp_q.push_back(16'h1025);
        exp_q.push_back(16'h5002); exp_q.push_back(16'h4003);
        start_run(1'b0);
        wait_halt(n);
`ifdef SEQ_STEP_EN
        chk("t2_halt_cycles", n, 32'd8);
`else
        chk("t2_halt_cycles", n, 32'd6);
`endif
        chk("t2_final_pc", {20'd0, pc}, 32'h003);
        end_test("t2_queue_empty");

        // Unconditional jump; start held high must not restart after halt.
        do_reset(12'h000);
        rom[0] = 8'h84; rom[1] = 8'h10; rom[12'h410] = 8'hF0;
        exp_q.push_back(16'h5000); exp_q.push_back(16'h2410);
        exp_q.push_back(16'h5410); exp_q.push_back(16'h4411);
        start_run(1'b1);
        wait_halt(n);
        end_test("t3_queue_empty");

        // JZ not taken: skip the target byte.
        do_reset(12'h000);
        bus.flag_z = 1'b0;
        rom[0] = 8'h91; rom[1] = 8'h22; rom[2] = 8'hF0;
        exp_q.push_back(16'h5000); exp_q.push_back(16'h3001);
        exp_q.push_back(16'h5002); exp_q.push_back(16'h4003);
        start_run(1'b0);
        wait_halt(n);
        end_test("t4a_queue_empty");

        // JZ taken.
        do_reset(12'h000);
        bus.flag_z = 1'b1;
        rom[0] = 8'h91; rom[1] = 8'h22; rom[12'h122] = 8'hF0;
        exp_q.push_back(16'h5000); exp_q.push_back(16'h2122);
        exp_q.push_back(16'h5122); exp_q.push_back(16'h4123);
        start_run(1'b0);
        wait_halt(n);
        end_test("t4b_queue_empty");
        bus.flag_z = 1'b0;

        // JMP at 0xFFF takes its low byte from 0x000 after PC wrap.
        do_reset(12'hFFF);
        rom[12'hFFF] = 8'h8A; rom[0] = 8'h07; rom[12'hA07] = 8'hF0;
        exp_q.push_back(16'h5FFF); exp_q.push_back(16'h2A07);
        exp_q.push_back(16'h5A07); exp_q.push_back(16'h4A08);
        start_run(1'b0);
        wait_halt(n);
        end_test("t5_queue_empty");

`ifdef SEQ_STEP_EN
        // Single step: park in S_WAIT until a one-cycle step pulse.
        do_reset(12'h000);
        bus.step = 1'b0;
        rom[0] = 8'h13; rom[1] = 8'hF0;
        exp_q.push_back(16'h5000); exp_q.push_back(16'h1013);
        start_run(1'b0);
        repeat (5) @(negedge clk);
        #1;
        chk("t6_wait_state", {29'd0, state_o}, 32'd6);
        chk("t6_wait_busy", {31'd0, bus.busy}, 32'd1);
        chk("t6_wait_enables", {28'd0, bus.ENPC, bus.ENF, bus.blo, bus.exec_en}, 32'd0);
        chk("t6_wait_queue", exp_q.size(), 32'd0);
        exp_q.push_back(16'h5001); exp_q.push_back(16'h4002);
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        wait_halt(n);
        end_test("t6_queue_empty");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
